// File: rtl/huff_pkg.sv
// Shared definitions for the Huffman encoder sequencer.
// Latency: n/a (types, constants and a layout helper only).
// Backpressure: n/a.
//
// Table entry layout is {len, code}: code occupies the low CODE_W bits and
// len sits directly above it.
package huff_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_LOAD  = 2'd1,
    ST_ENC   = 2'd2,
    ST_DRAIN = 2'd3
  } state_t;

  localparam logic MODE_LOAD = 1'b0;
  localparam logic MODE_ENC  = 1'b1;

  // Field offsets inside a {len, code} table entry.
  localparam int ENT_CODE_LSB = 0;

  function automatic int ent_len_lsb(input int code_w);
    return code_w;
  endfunction

endpackage

// File: rtl/huff_skid_buf.sv
// Two-entry output buffer between the table read and the concat stream.
// Latency: a push is visible at o_vld/o_dat the cycle after it is written.
// Backpressure: holds up to two entries under i_rdy=0; the producer must use
// o_cnt to avoid pushing into a full buffer that is not popping.
//
// Ports: clk/rst (sync, active-high); i_flush drops all entries;
// i_push/i_dat write side; i_rdy/o_vld/o_dat read side (head entry);
// o_cnt is the current occupancy (0..2).
module huff_skid_buf #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         i_flush,
  input  logic         i_push,
  input  logic [W-1:0] i_dat,
  input  logic         i_rdy,
  output logic         o_vld,
  output logic [W-1:0] o_dat,
  output logic [1:0]   o_cnt
);

  logic [W-1:0] r_head;
  logic [W-1:0] r_tail;
  logic [1:0]   r_cnt;
  logic         w_pop;

  assign o_vld = (r_cnt != 2'd0);
  assign o_dat = r_head;
  assign o_cnt = r_cnt;
  assign w_pop = o_vld && i_rdy;

  always_ff @(posedge clk) begin
    if (rst || i_flush) begin
      r_cnt  <= 2'd0;
      r_head <= '0;
      r_tail <= '0;
    end else begin
      case ({i_push, w_pop})
        2'b10: begin
          if (r_cnt == 2'd0) begin
            r_head <= i_dat;
            r_cnt  <= 2'd1;
          end else if (r_cnt == 2'd1) begin
            r_tail <= i_dat;
            r_cnt  <= 2'd2;
          end
        end
        2'b01: begin
          r_head <= r_tail;
          r_cnt  <= r_cnt - 2'd1;
        end
        2'b11: begin
          // Occupancy is unchanged; the new entry lands behind whatever
          // remains after the pop.
          if (r_cnt == 2'd1) begin
            r_head <= i_dat;
          end else begin
            r_head <= r_tail;
            r_tail <= i_dat;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/huff_enc_seq.sv
// Huffman encoder sequencer: loads a {len,code} table, then maps symbols to codes.
// Latency: symbol accepted in cycle t appears at m_* no earlier than t+2.
// Backpressure: s_ready drops when buffer plus in-flight read would exceed two entries.
//
// Ports: clk/rst (sync, active-high); start/mode/abort control with busy,
// done (1-cycle pulse) and sticky err; ld_* table-load stream; s_* symbol
// stream; tbl_* external table RAM (1-cycle read); m_* code output stream.
module huff_enc_seq
  import huff_pkg::*;
#(
  parameter int SYM_W  = 8,
  parameter int CODE_W = 64,
  parameter int LEN_W  = 7
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    start,
  input  logic                    mode,
  input  logic                    abort,
  output logic                    busy,
  output logic                    done,
  output logic                    err,
  input  logic                    ld_valid,
  output logic                    ld_ready,
  input  logic [CODE_W-1:0]       ld_code,
  input  logic [LEN_W-1:0]        ld_len,
  input  logic                    s_valid,
  output logic                    s_ready,
  input  logic [SYM_W-1:0]        s_sym,
  input  logic                    s_last,
  output logic                    tbl_we,
  output logic [SYM_W-1:0]        tbl_addr,
  output logic [CODE_W+LEN_W-1:0] tbl_wdata,
  input  logic [CODE_W+LEN_W-1:0] tbl_rdata,
  output logic                    m_valid,
  input  logic                    m_ready,
  output logic [CODE_W-1:0]       m_code,
  output logic [LEN_W-1:0]        m_len,
  output logic                    m_last
);

  localparam int ENT_W   = CODE_W + LEN_W;
  localparam int PAY_W   = ENT_W + 1;
  localparam int LEN_LSB = ent_len_lsb(CODE_W);
  localparam logic [LEN_W-1:0] MAX_LEN = LEN_W'(CODE_W);

  state_t           r_state;
  state_t           w_state_nxt;
  logic [SYM_W-1:0] r_ld_cnt;
  logic             r_err;
  logic             r_done;
  logic             r_rd_vld;
  logic             r_rd_last;

  logic             w_abort;
  logic             w_ld_beat;
  logic             w_load_end;
  logic             w_s_acc;
  logic             w_drain_end;
  logic             w_buf_push;
  logic             w_pop;
  logic [1:0]       w_buf_cnt;
  logic [2:0]       w_occ;
  logic [PAY_W-1:0] w_head;
  logic [LEN_W-1:0] w_rd_len;

  assign w_abort    = abort && (r_state != ST_IDLE);
  assign ld_ready   = (r_state == ST_LOAD);
  assign w_ld_beat  = ld_valid && ld_ready;
  assign w_load_end = w_ld_beat && (r_ld_cnt == {SYM_W{1'b1}});
  assign tbl_we     = w_ld_beat;
  assign tbl_wdata  = {ld_len, ld_code};

  // Accept only if, after this cycle's pop, at most one entry is held or in
  // flight: the read launched now then always has a slot to land in, while
  // a steady 1 symbol/cycle still flows when m_ready stays high.
  assign w_pop   = m_valid && m_ready;
  assign w_occ   = {1'b0, w_buf_cnt} + {2'b00, r_rd_vld};
  assign s_ready = (r_state == ST_ENC) && ((w_occ - {2'b00, w_pop}) <= 3'd1);
  assign w_s_acc = s_valid && s_ready;

  assign w_drain_end = (w_buf_cnt == 2'd0) && !r_rd_vld;
  assign w_buf_push  = r_rd_vld && !w_abort;
  assign w_rd_len    = tbl_rdata[LEN_LSB +: LEN_W];

  always_comb begin
    tbl_addr = '0;
    if (r_state == ST_LOAD) begin
      tbl_addr = r_ld_cnt;
    end else if (r_state == ST_ENC) begin
      tbl_addr = s_sym;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE: begin
        if (start && (mode == MODE_LOAD)) w_state_nxt = ST_LOAD;
        else if (start && (mode == MODE_ENC)) w_state_nxt = ST_ENC;
      end
      ST_LOAD:  if (w_abort || w_load_end) w_state_nxt = ST_IDLE;
      ST_ENC: begin
        if (w_abort) w_state_nxt = ST_IDLE;
        else if (w_s_acc && s_last) w_state_nxt = ST_DRAIN;
      end
      ST_DRAIN: if (w_abort || w_drain_end) w_state_nxt = ST_IDLE;
      default:  w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= ST_IDLE;
      r_ld_cnt  <= '0;
      r_err     <= 1'b0;
      r_done    <= 1'b0;
      r_rd_vld  <= 1'b0;
      r_rd_last <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_done    <= !w_abort &&
                   (((r_state == ST_LOAD) && w_load_end) ||
                    ((r_state == ST_DRAIN) && w_drain_end));
      r_rd_vld  <= w_s_acc && !w_abort;
      r_rd_last <= s_last;

      if (r_state == ST_IDLE) r_ld_cnt <= '0;
      else if (w_ld_beat)     r_ld_cnt <= r_ld_cnt + SYM_W'(1);

      // Bad-length load beats and undefined symbols (len=0) are still
      // written/forwarded; err just flags them until the next start.
      if ((r_state == ST_IDLE) && start) begin
        r_err <= 1'b0;
      end else if (!w_abort && ((w_ld_beat && (ld_len > MAX_LEN)) ||
                                (w_buf_push && (w_rd_len == '0)))) begin
        r_err <= 1'b1;
      end
    end
  end

  huff_skid_buf #(.W(PAY_W)) u_skid (
    .clk    (clk),
    .rst    (rst),
    .i_flush(w_abort),
    .i_push (w_buf_push),
    .i_dat  ({r_rd_last, tbl_rdata}),
    .i_rdy  (m_ready),
    .o_vld  (m_valid),
    .o_dat  (w_head),
    .o_cnt  (w_buf_cnt)
  );

  assign m_last = w_head[PAY_W-1];
  assign m_len  = w_head[LEN_LSB +: LEN_W];
  assign m_code = w_head[ENT_CODE_LSB +: CODE_W];
  assign busy   = (r_state != ST_IDLE);
  assign done   = r_done;
  assign err    = r_err;

endmodule

// File: tb/tb_huff_enc_seq.sv
// Testbench for huff_enc_seq with SYM_W=4: table RAM model, scoreboard of
// expected {last,len,code} entries pushed on symbol acceptance and popped on
// output delivery, plus scenario tasks for load, encode, stalls, err, abort, reset.
module tb_huff_enc_seq;
  localparam int SYM_W  = 4;
  localparam int CODE_W = 64;
  localparam int LEN_W  = 7;
  localparam int ENT_W  = CODE_W + LEN_W;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic              rst, start, mode, abort;
  logic              busy, done, err;
  logic              ld_valid, ld_ready;
  logic [CODE_W-1:0] ld_code;
  logic [LEN_W-1:0]  ld_len;
  logic              s_valid, s_ready, s_last;
  logic [SYM_W-1:0]  s_sym;
  logic              tbl_we;
  logic [SYM_W-1:0]  tbl_addr;
  logic [ENT_W-1:0]  tbl_wdata, tbl_rdata;
  logic              m_valid, m_ready, m_last;
  logic [CODE_W-1:0] m_code;
  logic [LEN_W-1:0]  m_len;

  huff_enc_seq #(.SYM_W(SYM_W), .CODE_W(CODE_W), .LEN_W(LEN_W)) dut (
    .clk(clk), .rst(rst), .start(start), .mode(mode), .abort(abort),
    .busy(busy), .done(done), .err(err),
    .ld_valid(ld_valid), .ld_ready(ld_ready), .ld_code(ld_code), .ld_len(ld_len),
    .s_valid(s_valid), .s_ready(s_ready), .s_sym(s_sym), .s_last(s_last),
    .tbl_we(tbl_we), .tbl_addr(tbl_addr), .tbl_wdata(tbl_wdata), .tbl_rdata(tbl_rdata),
    .m_valid(m_valid), .m_ready(m_ready), .m_code(m_code), .m_len(m_len), .m_last(m_last)
  );

  // Table RAM with 1-cycle read latency.
  logic [ENT_W-1:0] ram [16];
  always @(posedge clk) begin
    if (tbl_we) ram[tbl_addr] <= tbl_wdata;
    tbl_rdata <= ram[tbl_addr];
  end

  logic [ENT_W-1:0] exp_tbl [16];
  logic [ENT_W:0]   exp_q [$];
  int               del_cyc [$];
  logic [3:0]       sym_list [8];
  int occ = 0, n_full = 0, cyc = 0;
  int n_cmp = 0, n_err = 0;

  always @(posedge clk) cyc <= cyc + 1;

  // Scoreboard monitor, sampling 1 time unit after the falling edge.
  always begin
    logic [ENT_W:0] e;
    @(negedge clk);
    #1;
    if (occ == 2 && m_ready === 1'b0 && rst === 1'b0) begin
      n_full++;
      n_cmp++;
      if (s_ready !== 1'b0) begin
        n_err++;
        $display("FAIL full_stall: s_ready=%b required 0 with two entries held", s_ready);
      end
    end
    if (s_valid === 1'b1 && s_ready === 1'b1) begin
      exp_q.push_back({s_last, exp_tbl[s_sym]});
      occ++;
    end
    if (m_valid === 1'b1 && m_ready === 1'b1) begin
      n_cmp++;
      if (exp_q.size() == 0) begin
        n_err++;
        $display("FAIL sb_extra: got %h with nothing expected", {m_last, m_len, m_code});
      end else begin
        e = exp_q.pop_front();
        if ({m_last, m_len, m_code} !== e) begin
          n_err++;
          $display("FAIL sb_data: got %h required %h", {m_last, m_len, m_code}, e);
        end
      end
      del_cyc.push_back(cyc);
      occ--;
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  // Stimulus only: feeds sym_list[0..n-1] (last on final) until done is seen.
  task automatic run_enc(input int n, input bit toggle, input bit noise, output bit saw_done);
    int idx;
    logic [3:0] pat;
    idx = 0;
    pat = 4'b1001;
    saw_done = 1'b0;
    for (int c = 0; c < 300 && !saw_done; c++) begin
      @(negedge clk);
      m_ready = toggle ? pat[c[1:0]] : 1'b1;
      start   = noise;
      mode    = noise ? 1'b0 : 1'b1;
      if (idx < n) begin
        s_valid = 1'b1;
        s_sym   = sym_list[idx];
        s_last  = (idx == n - 1);
      end else begin
        s_valid = 1'b0;
        s_last  = 1'b0;
      end
      #1;
      if (done === 1'b1) saw_done = 1'b1;
      else if (s_valid && s_ready) idx++;
    end
    start = 1'b0; mode = 1'b1; s_valid = 1'b0; s_last = 1'b0; m_ready = 1'b1;
  endtask

  task automatic start_op(input logic m);
    @(negedge clk);
    start = 1'b1; mode = m;
    @(negedge clk);
    start = 1'b0;
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    #1;
    n_cmp++;
    if ({busy, done, err, ld_ready, s_ready, tbl_we, m_valid, m_last} !== 8'b0) begin
      n_err++;
      $display("FAIL reset_ctrl: got %b required 00000000",
               {busy, done, err, ld_ready, s_ready, tbl_we, m_valid, m_last});
    end
    n_cmp++;
    if (tbl_addr !== 4'd0 || m_code !== 64'd0 || m_len !== 7'd0) begin
      n_err++;
      $display("FAIL reset_data: addr=%h code=%h len=%h required all 0", tbl_addr, m_code, m_len);
    end
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_load(input int bad_sym, input int zero_sym);
    logic exp_err;
    exp_err = (bad_sym >= 0);
    start_op(1'b0);
    n_cmp++;
    if (busy !== 1'b1 || ld_ready !== 1'b1) begin
      n_err++;
      $display("FAIL load_enter: busy=%b ld_ready=%b required 1 1", busy, ld_ready);
    end
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      ld_valid = 1'b1;
      ld_code  = 64'(i);
      ld_len   = (i == bad_sym) ? 7'd100 : (i == zero_sym) ? 7'd0 : 7'(i + 1);
      exp_tbl[i] = {ld_len, ld_code};
      #1;
      n_cmp++;
      if (tbl_we !== 1'b1 || tbl_addr !== 4'(i) || tbl_wdata !== {ld_len, ld_code}) begin
        n_err++;
        $display("FAIL load_write[%0d]: we=%b addr=%0d wdata=%h required 1 %0d %h",
                 i, tbl_we, tbl_addr, tbl_wdata, i, {ld_len, ld_code});
      end
    end
    @(negedge clk);
    ld_valid = 1'b0;
    #1;
    n_cmp++;
    if (done !== 1'b1 || busy !== 1'b0) begin
      n_err++;
      $display("FAIL load_done: done=%b busy=%b required 1 0", done, busy);
    end
    n_cmp++;
    if (err !== exp_err) begin
      n_err++;
      $display("FAIL load_err: err=%b required %b", err, exp_err);
    end
    @(negedge clk);
    #1;
    n_cmp++;
    if (done !== 1'b0) begin
      n_err++;
      $display("FAIL load_done_pulse: done=%b required 0", done);
    end
  endtask

  task automatic test_enc_basic();
    bit saw;
    sym_list[0] = 4'd3; sym_list[1] = 4'd7; sym_list[2] = 4'd15;
    start_op(1'b1);
    del_cyc.delete();
    run_enc(3, 1'b0, 1'b0, saw);
    n_cmp++;
    if (!saw) begin
      n_err++;
      $display("FAIL enc_basic_done: done seen=%b required 1 within 300 cycles", saw);
    end
    n_cmp++;
    if (del_cyc.size() != 3 || exp_q.size() != 0) begin
      n_err++;
      $display("FAIL enc_basic_count: delivered=%0d pending=%0d required 3 0",
               del_cyc.size(), exp_q.size());
    end
    if (del_cyc.size() == 3) begin
      n_cmp++;
      if (del_cyc[1] != del_cyc[0] + 1 || del_cyc[2] != del_cyc[1] + 1) begin
        n_err++;
        $display("FAIL enc_back_to_back: cycles %0d %0d %0d required consecutive",
                 del_cyc[0], del_cyc[1], del_cyc[2]);
      end
    end
    n_cmp++;
    if (err !== 1'b0 || busy !== 1'b0) begin
      n_err++;
      $display("FAIL enc_basic_end: err=%b busy=%b required 0 0", err, busy);
    end
  endtask

  task automatic test_backpressure();
    bit saw;
    sym_list[0] = 4'd0;  sym_list[1] = 4'd5; sym_list[2] = 4'd10; sym_list[3] = 4'd15;
    sym_list[4] = 4'd1;  sym_list[5] = 4'd14; sym_list[6] = 4'd2; sym_list[7] = 4'd13;
    start_op(1'b1);
    del_cyc.delete();
    n_full = 0;
    // start held high with mode=0 throughout must be ignored while busy.
    run_enc(8, 1'b1, 1'b1, saw);
    n_cmp++;
    if (!saw) begin
      n_err++;
      $display("FAIL bp_done: done seen=%b required 1 within 300 cycles", saw);
    end
    n_cmp++;
    if (del_cyc.size() != 8 || exp_q.size() != 0) begin
      n_err++;
      $display("FAIL bp_count: delivered=%0d pending=%0d required 8 0",
               del_cyc.size(), exp_q.size());
    end
    n_cmp++;
    if (n_full == 0) begin
      n_err++;
      $display("FAIL bp_full_seen: full-and-stalled cycles=%0d required >0", n_full);
    end
    n_cmp++;
    if (err !== 1'b0) begin
      n_err++;
      $display("FAIL bp_err: err=%b required 0", err);
    end
  endtask

  task automatic test_undefined();
    bit saw;
    test_load(12, 9);
    start_op(1'b1);
    n_cmp++;
    if (err !== 1'b0) begin
      n_err++;
      $display("FAIL undef_err_clear: err=%b required 0 after start", err);
    end
    sym_list[0] = 4'd2; sym_list[1] = 4'd9; sym_list[2] = 4'd4;
    run_enc(3, 1'b0, 1'b0, saw);
    n_cmp++;
    if (!saw || err !== 1'b1) begin
      n_err++;
      $display("FAIL undef_err_at_done: done=%b err=%b required 1 1", saw, err);
    end
    @(negedge clk);
    #1;
    n_cmp++;
    if (err !== 1'b1) begin
      n_err++;
      $display("FAIL undef_err_sticky: err=%b required 1", err);
    end
    start_op(1'b1);
    n_cmp++;
    if (err !== 1'b0) begin
      n_err++;
      $display("FAIL undef_err_restart: err=%b required 0", err);
    end
    sym_list[0] = 4'd1;
    run_enc(1, 1'b0, 1'b0, saw);
    n_cmp++;
    if (!saw || err !== 1'b0) begin
      n_err++;
      $display("FAIL undef_clean_run: done=%b err=%b required 1 0", saw, err);
    end
  endtask

  task automatic test_abort();
    int idx;
    bit saw;
    start_op(1'b1);
    idx = 0;
    for (int c = 0; c < 20 && idx < 2; c++) begin
      @(negedge clk);
      m_ready = 1'b0;
      s_valid = 1'b1;
      s_sym   = (idx == 0) ? 4'd9 : 4'd2;
      s_last  = 1'b0;
      #1;
      if (s_ready) idx++;
    end
    @(negedge clk);
    s_valid = 1'b0;
    abort = 1'b1;
    @(posedge clk);
    exp_q.delete();
    occ = 0;
    @(negedge clk);
    abort = 1'b0;
    #1;
    n_cmp++;
    if (idx != 2 || m_valid !== 1'b0 || busy !== 1'b0 || done !== 1'b0) begin
      n_err++;
      $display("FAIL abort_state: accepted=%0d m_valid=%b busy=%b done=%b required 2 0 0 0",
               idx, m_valid, busy, done);
    end
    n_cmp++;
    if (err !== 1'b1) begin
      n_err++;
      $display("FAIL abort_err_kept: err=%b required 1", err);
    end
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      #1;
      n_cmp++;
      if (done !== 1'b0 || m_valid !== 1'b0) begin
        n_err++;
        $display("FAIL abort_quiet: done=%b m_valid=%b required 0 0", done, m_valid);
      end
    end
    m_ready = 1'b1;
    start_op(1'b1);
    del_cyc.delete();
    sym_list[0] = 4'd0; sym_list[1] = 4'd1; sym_list[2] = 4'd2;
    run_enc(3, 1'b0, 1'b0, saw);
    n_cmp++;
    if (!saw || err !== 1'b0 || del_cyc.size() != 3 || exp_q.size() != 0) begin
      n_err++;
      $display("FAIL abort_rerun: done=%b err=%b delivered=%0d pending=%0d required 1 0 3 0",
               saw, err, del_cyc.size(), exp_q.size());
    end
  endtask

  task automatic test_reset_mid_load();
    start_op(1'b0);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      ld_valid = 1'b1;
      ld_code  = 64'(i);
      ld_len   = (i == 2) ? 7'd100 : 7'(i + 1);
    end
    @(negedge clk);
    ld_code = 64'd5;
    ld_len  = 7'd6;
    #1;
    n_cmp++;
    if (err !== 1'b1 || tbl_addr !== 4'd5) begin
      n_err++;
      $display("FAIL midload_pre: err=%b addr=%0d required 1 5", err, tbl_addr);
    end
    rst = 1'b1;
    abort = 1'b1;
    @(negedge clk);
    #1;
    n_cmp++;
    if ({busy, done, err, ld_ready, s_ready, tbl_we, m_valid, m_last} !== 8'b0) begin
      n_err++;
      $display("FAIL midload_rst_ctrl: got %b required 00000000",
               {busy, done, err, ld_ready, s_ready, tbl_we, m_valid, m_last});
    end
    n_cmp++;
    if (tbl_addr !== 4'd0 || m_code !== 64'd0 || m_len !== 7'd0) begin
      n_err++;
      $display("FAIL midload_rst_data: addr=%h code=%h len=%h required all 0", tbl_addr, m_code, m_len);
    end
    rst = 1'b0;
    abort = 1'b0;
    ld_valid = 1'b0;
    test_load(-1, -1);
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; mode = 1'b0; abort = 1'b0;
    ld_valid = 1'b0; ld_code = '0; ld_len = '0;
    s_valid = 1'b0; s_sym = '0; s_last = 1'b0; m_ready = 1'b1;
    test_reset();
    test_load(-1, -1);
    test_enc_basic();
    test_backpressure();
    test_undefined();
    test_abort();
    test_reset_mid_load();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
